// File: rtl/can_tx_scheduler_if.sv
// Transmitter-side bus shared between the scheduler and the CAN transmitter.
// The scheduler drives the launch strobe and frame fields; the transmitter
// returns its busy level and the per-attempt outcome pulses.
interface can_tx_scheduler_if #(
    parameter int ID_W = 11
);
    logic            tx_start;
    logic [ID_W-1:0] tx_id;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            tx_done;
    logic            tx_arb_lost;
    logic            tx_error;

    modport master (
        output tx_start, tx_id, tx_data,
        input  tx_busy, tx_done, tx_arb_lost, tx_error
    );

    modport slave (
        input  tx_start, tx_id, tx_data,
        output tx_busy, tx_done, tx_arb_lost, tx_error
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: arbitrates four requesters by identifier (lowest
// wins, ties to the lowest index), launches the winner, retries after lost
// arbitration / bus error / response timeout, enforces an idle gap after
// every attempt and reports done or fail per requester.
module can_tx_scheduler #(
    parameter int ID_W         = 11,
    parameter int MAX_RETRY    = 3,
    parameter int IFS_BITS     = 3,
    parameter int TIMEOUT_BITS = 200
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                bit_tick,
    input  logic [3:0]          req,
    input  logic [4*ID_W-1:0]   req_id,
    input  logic [31:0]         req_data,
    output logic [3:0]          req_done,
    output logic [3:0]          req_fail,
    output logic                busy,
    output logic [1:0]          active_idx,
    can_tx_scheduler_if.master  tx
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_IFS    = 2'd3
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [3:0] IFS_LAST    = 4'(IFS_BITS - 1);
    localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_BITS - 1);

    state_t          state_q;
    logic [3:0]      retry_q;
    logic [1:0]      last_idx_q;
    logic [1:0]      active_idx_q;
    logic [7:0]      timeout_q;
    logic [3:0]      ifs_q;
    logic            tx_start_q;
    logic [ID_W-1:0] tx_id_q;
    logic [7:0]      tx_data_q;
    logic [3:0]      done_q;
    logic [3:0]      fail_q;
    logic            busy_q;

    logic [1:0]      win_idx_d;
    logic [ID_W-1:0] win_id_d;
    logic            win_found_d;
    logic [7:0]      win_data_d;
    logic [3:0]      retry_d;
    logic [3:0]      active_oh_d;
    logic            timeout_hit_d;
    logic            attempt_lost_d;

    // Winner search: strict less-than keeps the lowest index on equal ids.
    always_comb begin
        win_idx_d   = 2'd0;
        win_id_d    = {ID_W{1'b0}};
        win_found_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic take;
            take        = req[i] && (!win_found_d || (req_id[i*ID_W +: ID_W] < win_id_d));
            win_found_d = win_found_d | take;
            win_idx_d   = take ? 2'(i) : win_idx_d;
            win_id_d    = take ? req_id[i*ID_W +: ID_W] : win_id_d;
        end
        win_data_d = req_data[{win_idx_d, 3'b000} +: 8];
    end

    // Attempt outcome helpers used while waiting on the transmitter.
    always_comb begin
        retry_d        = retry_q + 4'd1;
        active_oh_d    = 4'b0001 << active_idx_q;
        timeout_hit_d  = bit_tick && (timeout_q == TO_LAST);
        attempt_lost_d = tx.tx_error || tx.tx_arb_lost || timeout_hit_d;
    end

    // Scheduler state machine with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            retry_q      <= 4'd0;
            last_idx_q   <= 2'd0;
            active_idx_q <= 2'd0;
            timeout_q    <= 8'd0;
            ifs_q        <= 4'd0;
            tx_start_q   <= 1'b0;
            tx_id_q      <= {ID_W{1'b0}};
            tx_data_q    <= 8'd0;
            done_q       <= 4'd0;
            fail_q       <= 4'd0;
            busy_q       <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 4'd0;
            fail_q     <= 4'd0;
            case (state_q)
                ST_IDLE: begin
                    if ((|req) && !tx.tx_busy) begin
                        tx_id_q      <= win_id_d;
                        tx_data_q    <= win_data_d;
                        active_idx_q <= win_idx_d;
                        // A different winner starts a fresh retry budget.
                        if (win_idx_d != last_idx_q) begin
                            retry_q <= 4'd0;
                        end
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    timeout_q <= 8'd0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bit_tick) begin
                        timeout_q <= timeout_q + 8'd1;
                    end
                    if (tx.tx_done) begin
                        done_q  <= active_oh_d;
                        retry_q <= 4'd0;
                        ifs_q   <= 4'd0;
                        state_q <= ST_IFS;
                    end else if (attempt_lost_d) begin
                        last_idx_q <= active_idx_q;
                        ifs_q      <= 4'd0;
                        state_q    <= ST_IFS;
                        if (retry_d == RETRY_LIMIT) begin
                            fail_q  <= active_oh_d;
                            retry_q <= 4'd0;
                        end else begin
                            retry_q <= retry_d;
                        end
                    end
                end
                ST_IFS: begin
                    if (bit_tick) begin
                        if (ifs_q == IFS_LAST) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            ifs_q <= ifs_q + 4'd1;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_start = tx_start_q;
    assign tx.tx_id    = tx_id_q;
    assign tx.tx_data  = tx_data_q;
    assign req_done    = done_q;
    assign req_fail    = fail_q;
    assign busy        = busy_q;
    assign active_idx  = active_idx_q;

endmodule
